// File: rtl/canonical_row_streamer.sv
`default_nettype none
// ============================================================================
// Module  : canonical_row_streamer
// Brief   : Sequencer and valid/ready row-stream endpoint for the canonical-
//           reduction cell chain. Optional macro CANON_STREAM_ROWCHK_EN adds
//           the row_err output (row count check at end of pass).
// Rev     : 1.0  initial release
// ============================================================================
module canonical_row_streamer #(
   parameter int NUM_QUBIT   = 4,
   parameter int CHAIN_DEPTH = 2*NUM_QUBIT
) (
   input  logic                               clk,
   input  logic                               rst_new_n,
   input  logic                               start,
   output logic                               busy,
   output logic                               done,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [2*NUM_QUBIT-1:0]             in_literals,
   input  logic                               in_phase,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [2*NUM_QUBIT-1:0]             out_literals,
   output logic                               out_phase,
   output logic [$clog2(CHAIN_DEPTH+1)-1:0]   out_count,
   output logic                               chain_clr,
   output logic                               chain_ld_trans,
   output logic                               chain_ld_store,
   output logic                               chain_second_stage,
   output logic                               chain_second_CR,
   output logic [2*NUM_QUBIT-1:0]             head_literals,
   output logic                               head_phase,
   output logic                               head_flag,
   input  logic [2*NUM_QUBIT-1:0]             tail_literals,
   input  logic                               tail_phase,
   input  logic                               tail_flag
`ifdef CANON_STREAM_ROWCHK_EN
   ,
   output logic                               row_err
`endif
);

   localparam int CW = $clog2(CHAIN_DEPTH+1);
   localparam logic [CW-1:0] c_feed_last  = CW'(NUM_QUBIT-1);
   localparam logic [CW-1:0] c_chain_last = CW'(CHAIN_DEPTH-1);
   localparam logic [CW-1:0] c_depth      = CW'(CHAIN_DEPTH);
   localparam logic [CW-1:0] c_one        = CW'(1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_FEED  = 3'd2,
      S_FLUSH = 3'd3,
      S_DRAIN = 3'd4,
      S_FIN   = 3'd5
   } state_t;

   state_t         r_state;
   logic           r_busy;
   logic           r_done;
   logic           r_clr;
   logic           r_second;
   logic [CW-1:0]  r_step_cnt;
   logic [CW-1:0]  r_out_count;

   logic           w_feed;
   logic           w_active;
   logic           w_out_ok;
   logic           w_step;
   logic           w_last;
   logic [CW-1:0]  w_out_count_nxt;

   assign w_feed   = (r_state == S_FEED);
   assign w_active = w_feed || (r_state == S_FLUSH) || (r_state == S_DRAIN);

   // Tail rows pass straight through; unflagged rows are never presented.
   assign out_valid    = w_active & tail_flag;
   assign out_literals = tail_literals;
   assign out_phase    = tail_phase;

   assign w_out_ok = !out_valid || out_ready;
   assign w_step   = (w_feed ? in_valid : w_active) && w_out_ok;
   assign w_last   = (r_step_cnt == (w_feed ? c_feed_last : c_chain_last));

   assign in_ready       = w_feed && w_out_ok;
   assign chain_ld_trans = w_step;
   assign chain_ld_store = w_step;

   assign head_literals = w_feed ? in_literals : '0;
   assign head_phase    = w_feed ? in_phase    : 1'b0;
   assign head_flag     = w_feed;

   assign w_out_count_nxt = (out_valid && out_ready && (r_out_count != c_depth))
                            ? r_out_count + c_one : r_out_count;

   assign busy               = r_busy;
   assign done               = r_done;
   assign chain_clr          = r_clr;
   assign chain_second_stage = r_second;
   assign chain_second_CR    = r_second;
   assign out_count          = r_out_count;

`ifdef CANON_STREAM_ROWCHK_EN
   logic r_row_err;
   assign row_err = r_row_err;
`endif

   always_ff @(posedge clk or negedge rst_new_n) begin
      if (!rst_new_n) begin
         r_state     <= S_IDLE;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_clr       <= 1'b1;
         r_second    <= 1'b0;
         r_step_cnt  <= '0;
         r_out_count <= '0;
`ifdef CANON_STREAM_ROWCHK_EN
         r_row_err   <= 1'b0;
`endif
      end else begin
         r_done      <= 1'b0;
         r_clr       <= 1'b0;
         r_out_count <= w_out_count_nxt;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_CLEAR;
                  r_busy  <= 1'b1;
                  r_clr   <= 1'b1;
               end
            end
            S_CLEAR: begin
               r_state     <= S_FEED;
               r_step_cnt  <= '0;
               r_out_count <= '0;
`ifdef CANON_STREAM_ROWCHK_EN
               r_row_err   <= 1'b0;
`endif
            end
            S_FEED, S_FLUSH, S_DRAIN: begin
               if (w_step) begin
                  if (w_last) begin
                     r_step_cnt <= '0;
                     if (r_state == S_FEED) begin
                        r_state <= S_FLUSH;
                     end else if (r_state == S_FLUSH) begin
                        r_state  <= S_DRAIN;
                        r_second <= 1'b1;
                     end else begin
                        r_state  <= S_FIN;
                        r_second <= 1'b0;
                        r_done   <= 1'b1;
`ifdef CANON_STREAM_ROWCHK_EN
                        // Uses the next count so a row taken on the final step is included.
                        r_row_err <= (w_out_count_nxt != CW'(NUM_QUBIT));
`endif
                     end
                  end else begin
                     r_step_cnt <= r_step_cnt + c_one;
                  end
               end
            end
            S_FIN: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
